// File: rtl/icache_fetch_requester.sv
// Instruction-fetch requester: issues sequential word addresses to the I-cache,
// tracks in-flight requests, and queues returned words with their PCs for decode.
module icache_fetch_requester #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_addr_ready,
  output logic        io_addr_valid,
  output logic [31:0] io_addr_bits,
  output logic        io_data_ready,
  input  logic        io_data_valid,
  input  logic [31:0] io_data_bits,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_bits,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]    pc;
  logic [31:0]    held_addr;
  logic           pend_q;
  logic           stale_pend;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  inflight_nx;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  qcount;
  logic [CW:0]    used;
  logic [AW-1:0]  iw_ptr, ir_ptr, qw_ptr, qr_ptr;

  logic [31:0]      ifa_addr [DEPTH];
  logic [DEPTH-1:0] ifa_stale;
  logic [31:0]      q_bits [DEPTH];
  logic [31:0]      q_pc   [DEPTH];

  logic        credit_ok, addr_fire, resp_fire, head_stale;
  logic        discard, enq, deq, push_stale;
  logic [31:0] redir_tgt;

  always_comb begin
    used          = {1'b0, inflight} + {1'b0, qcount};
    credit_ok     = used < (CW+1)'(DEPTH);
    // A shown request stays up (same address) until accepted, whatever the credit.
    io_addr_valid = reset && (pend_q || credit_ok);
    io_addr_bits  = pend_q ? held_addr : pc;
    io_data_ready = reset;
    addr_fire     = io_addr_valid && io_addr_ready;
    resp_fire     = io_data_valid && io_data_ready && (inflight != '0);
    head_stale    = ifa_stale[ir_ptr];
    discard       = head_stale || (drop_cnt != '0) || redirect_valid;
    enq           = resp_fire && !discard;
    inst_valid    = reset && (qcount != '0);
    deq           = inst_valid && inst_ready && !redirect_valid;
    push_stale    = stale_pend || redirect_valid;
    inflight_nx   = inflight + CW'(addr_fire) - CW'(resp_fire);
    redir_tgt     = redirect_pc & ~32'h3;
    inst_bits     = q_bits[qr_ptr];
    inst_pc       = q_pc[qr_ptr];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc         <= RESET_PC;
      pend_q     <= 1'b0;
      stale_pend <= 1'b0;
      inflight   <= '0;
      drop_cnt   <= '0;
      qcount     <= '0;
      iw_ptr     <= '0;
      ir_ptr     <= '0;
      qw_ptr     <= '0;
      qr_ptr     <= '0;
    end else begin
      pend_q <= io_addr_valid && !io_addr_ready;
      if (addr_fire)
        stale_pend <= 1'b0;
      else if (redirect_valid && io_addr_valid)
        stale_pend <= 1'b1;

      // A held-over stale request was fetched from the old stream; pc already holds the target.
      if (redirect_valid)
        pc <= redir_tgt;
      else if (addr_fire && !stale_pend)
        pc <= pc + 32'd4;

      inflight <= inflight_nx;
      // drop_cnt tracks how many issue-FIFO entries are stale.
      if (redirect_valid)
        drop_cnt <= inflight_nx;
      else
        drop_cnt <= drop_cnt - CW'(resp_fire && head_stale) + CW'(addr_fire && push_stale);

      if (addr_fire) iw_ptr <= iw_ptr + AW'(1);
      if (resp_fire) ir_ptr <= ir_ptr + AW'(1);

      if (redirect_valid) begin
        qcount <= '0;
        qw_ptr <= '0;
        qr_ptr <= '0;
      end else begin
        qcount <= qcount + CW'(enq) - CW'(deq);
        if (enq) qw_ptr <= qw_ptr + AW'(1);
        if (deq) qr_ptr <= qr_ptr + AW'(1);
      end
    end
  end

  // Payload storage; only entries covered by the control pointers are ever read.
  always_ff @(posedge clock) begin
    if (!pend_q)
      held_addr <= pc;
    if (redirect_valid) begin
      for (int i = 0; i < DEPTH; i++)
        ifa_stale[i] <= 1'b1;
    end
    if (addr_fire) begin
      ifa_addr[iw_ptr]  <= io_addr_bits;
      ifa_stale[iw_ptr] <= push_stale;
    end
    if (enq) begin
      q_bits[qw_ptr] <= io_data_bits;
      q_pc[qw_ptr]   <= ifa_addr[ir_ptr];
    end
  end

endmodule

// File: tb/tb_icache_fetch_requester.sv
// Randomized bench for icache_fetch_requester with a transaction-level cache and
// decode-queue reference model.
module tb_icache_fetch_requester;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;
  localparam int          DEPTH = 4;

  logic        clock, reset;
  logic        io_addr_ready, io_addr_valid, io_data_ready, io_data_valid;
  logic [31:0] io_addr_bits, io_data_bits;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, inst_bits, inst_pc;

  icache_fetch_requester #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_addr_ready(io_addr_ready), .io_addr_valid(io_addr_valid), .io_addr_bits(io_addr_bits),
    .io_data_ready(io_data_ready), .io_data_valid(io_data_valid), .io_data_bits(io_data_bits),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bits(inst_bits), .inst_pc(inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int rdy; bit stale; } creq_t;
  typedef struct { logic [31:0] bits; logic [31:0] pc; } inst_t;
  creq_t cq[$];
  inst_t mq[$];

  int errors = 0, checks = 0, cyc = 0;
  int p_ar = 100, p_ir = 100, p_rd = 0, max_lat = 0;
  bit resp_en = 1, rst_req = 1, force_redir = 0, redir_on_busy = 0, busy_hit = 0;
  logic [31:0] redir_tgt_k = 32'h0;
  logic [31:0] next_issue, exp_pc, pend_addr;
  bit held_over = 0, pend_prev = 0;
  int n_issue = 0, n_deliv = 0;
  logic [31:0] iss_log [8];
  logic [31:0] dpc [8];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cq.delete();
    mq.delete();
    next_issue = RPC;
    exp_pc     = RPC;
    held_over  = 0;
    pend_prev  = 0;
  endtask

  task automatic sample();
    creq_t r;
    logic [31:0] tgt, expa;
    bit ho;
    if (!reset) begin
      chk("rst_addr_valid", io_addr_valid, 0);
      chk("rst_data_ready", io_data_ready, 0);
      chk("rst_inst_valid", inst_valid, 0);
      model_clear();
      return;
    end
    chk("data_ready", io_data_ready, 1);
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() > 0) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_bits", inst_bits, mq[0].bits);
    end
    if (pend_prev) begin
      chk("hold_valid", io_addr_valid, 1);
      chk("hold_bits", io_addr_bits, pend_addr);
    end else begin
      chk("credit", io_addr_valid, (cq.size() + mq.size()) < DEPTH);
    end
    // decode pop
    if (inst_valid && inst_ready && !redirect_valid && mq.size() > 0) begin
      chk("seq_pc", inst_pc, exp_pc);
      exp_pc = inst_pc + 32'd4;
      if (n_deliv < 8) dpc[n_deliv] = inst_pc;
      n_deliv++;
      void'(mq.pop_front());
    end
    // cache response
    if (io_data_valid && io_data_ready && cq.size() > 0) begin
      r = cq.pop_front();
      if (!r.stale && !redirect_valid) mq.push_back('{bits: hash(r.addr), pc: r.addr});
    end
    // address handshake
    if (io_addr_valid && io_addr_ready) begin
      ho   = held_over;
      expa = ho ? pend_addr : next_issue;
      chk("issue_addr", io_addr_bits, expa);
      cq.push_back('{addr: io_addr_bits, rdy: cyc + 1 + $urandom_range(max_lat, 0),
                     stale: ho || redirect_valid});
      chk("inflight_max", cq.size() <= DEPTH, 1);
      if (!ho) next_issue = io_addr_bits + 32'd4;
      held_over = 0;
      if (n_issue < 8) iss_log[n_issue] = io_addr_bits;
      n_issue++;
    end
    pend_prev = io_addr_valid && !io_addr_ready;
    if (pend_prev) pend_addr = io_addr_bits;
    if (redirect_valid) begin
      tgt = redirect_pc & ~32'h3;
      foreach (cq[i]) cq[i].stale = 1;
      mq.delete();
      exp_pc     = tgt;
      next_issue = tgt;
      if (io_addr_valid && !io_addr_ready) held_over = 1;
    end
  endtask

  task automatic step();
    @(negedge clock);
    reset          = !rst_req;
    io_addr_ready  = ($urandom_range(99, 0) < p_ar);
    inst_ready     = ($urandom_range(99, 0) < p_ir);
    redirect_valid = force_redir || ($urandom_range(99, 0) < p_rd);
    redirect_pc    = force_redir ? redir_tgt_k : $urandom;
    io_data_valid  = resp_en && cq.size() > 0 && cq[0].rdy <= cyc;
    io_data_bits   = io_data_valid ? hash(cq[0].addr) : $urandom;
    #1;
    if (redir_on_busy && reset && inst_valid && inst_ready && io_data_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt_k;
      redir_on_busy  = 0;
      busy_hit       = 1;
      #1;
    end
    sample();
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_req = 1;
    repeat (n) step();
    rst_req = 0;
    n_issue = 0;
    n_deliv = 0;
  endtask

  task automatic run_until_deliv(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_deliv < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, n_deliv >= n, 1);
  endtask

  initial begin
    reset = 0; io_addr_ready = 0; inst_ready = 0; redirect_valid = 0;
    redirect_pc = 0; io_data_valid = 0; io_data_bits = 0;
    model_clear();

    // Streaming, no stalls
    p_ar = 100; p_ir = 100; p_rd = 0; max_lat = 0; resp_en = 1;
    do_reset(2);
    for (int k = 0; k < 12; k++) begin
      step();
      if (k < 3) begin
        chk("t1_issue_v", io_addr_valid, 1);
        chk("t1_issue_a", io_addr_bits, RPC + 32'(4 * k));
      end
    end
    chk("t1_nostall", n_deliv, 10);

    // Decode stall fills the credit window
    do_reset(1);
    p_ir = 0;
    repeat (10) step();
    chk("t2_issues", n_issue, 4);
    chk("t2_stalled", io_addr_valid, 0);
    p_ir = 100; n_issue = 0;
    run_until_deliv(4, 20, "t2_drain");
    chk("t2_resume", iss_log[0], RPC + 32'h10);

    // Redirect with three requests in flight
    do_reset(1);
    resp_en = 0;
    repeat (3) step();
    force_redir = 1; redir_tgt_k = 32'h80;
    step();
    force_redir = 0; resp_en = 1; max_lat = 1; n_deliv = 0;
    run_until_deliv(2, 40, "t3_deliv");
    chk("t3_first", dpc[0], 32'h80);
    chk("t3_second", dpc[1], 32'h84);

    // Redirect while a request is held
    do_reset(1);
    max_lat = 0;
    step();
    p_ar = 0;
    step();
    force_redir = 1; redir_tgt_k = 32'h40;
    step();
    force_redir = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_hold", io_addr_bits, RPC + 32'h4);
    end
    p_ar = 100; n_issue = 0; n_deliv = 0;
    step(); step();
    chk("t4_held_issue", iss_log[0], RPC + 32'h4);
    chk("t4_next_issue", iss_log[1], 32'h40);
    run_until_deliv(1, 20, "t4_deliv");
    chk("t4_first", dpc[0], 32'h40);

    // Redirect coincident with a response and a decode pop
    do_reset(1);
    repeat (4) step();
    busy_hit = 0; redir_on_busy = 1; redir_tgt_k = 32'h200;
    for (int k = 0; k < 10 && !busy_hit; k++) step();
    chk("t5_hit", busy_hit, 1);
    n_deliv = 0;
    step();
    chk("t5_flushed", inst_valid, 0);
    run_until_deliv(1, 20, "t5_deliv");
    chk("t5_first", dpc[0], 32'h200);

    // Reset mid-stream with two in flight
    do_reset(1);
    resp_en = 0;
    repeat (2) step();
    rst_req = 1;
    step();
    rst_req = 0; resp_en = 1; n_issue = 0; n_deliv = 0;
    step();
    chk("t6_restart", iss_log[0], RPC);
    run_until_deliv(3, 20, "t6_deliv");
    chk("t6_first", dpc[0], RPC);

    // Random traffic
    p_ar = 60; p_ir = 60; p_rd = 3; max_lat = 4;
    for (int k = 0; k < 3000; k++) begin
      rst_req = ($urandom_range(499, 0) == 0);
      step();
    end
    rst_req = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/icache_fetch_requester.md
Name: icache_fetch_requester

Overview:
- Instruction-fetch front end that drives the instruction cache's address/data valid-ready interface from the requesting side.
- Generates sequential fetch addresses and tracks in-flight requests.
- Buffers returned instructions with their PCs and hands them to decode.
- Handles branch redirects by flushing and discarding stale responses, so the cache may keep any number of requests (up to DEPTH) in flight.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- DEPTH, 4, in-flight plus buffered instruction limit; power of two, 2..16.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- io_addr_ready  in  1  cache accepts an address.
- io_addr_valid  out  1  fetch address valid.
- io_addr_bits  out  32  fetch address, word aligned.
- io_data_ready  out  1  requester accepts a response.
- io_data_valid  in  1  cache response valid.
- io_data_bits  in  32  instruction word.
- redirect_valid  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  32  redirect target; bits[1:0] are ignored and forced to 0.
- inst_valid  out  1  decode-side instruction valid.
- inst_ready  in  1  decode accepts the instruction.
- inst_bits  out  32  instruction word.
- inst_pc  out  32  PC of inst_bits.

Behaviour:
- Reset (reset==0 at posedge):
  - pc<=RESET_PC; inflight<=0; drop_cnt<=0; stale_pend<=0.
  - Issue FIFO and instruction queue emptied.
  - Outputs io_addr_valid=0, io_data_ready=0, inst_valid=0.
  - Reset mid-transaction abandons all in-flight state; no pending handshake is honoured.
- First cycle after reset release: io_addr_valid=1, io_addr_bits=RESET_PC, io_data_ready=1.
- io_data_ready is 1 in every non-reset cycle. Credit accounting guarantees the queue cannot overflow.
- Issue rule:
  - io_addr_valid=1 when (inflight + qcount) < DEPTH, or when a request is already pending (valid shown, no ready yet).
  - Once asserted, io_addr_valid and io_addr_bits hold stable until io_addr_ready. This applies across redirects.
- Address handshake (valid&&ready):
  - inflight+1.
  - The issued address is pushed into the issue FIFO with a stale flag.
  - pc<=pc+4 (wraps at 2^32) unless stale_pend.
- Response handshake:
  - inflight-1.
  - The issue FIFO head is popped.
  - If the head is stale or drop_cnt>0: the word is discarded and drop_cnt decremented where applicable.
  - Otherwise {io_data_bits, head address} is pushed to the instruction queue.
- Decode side:
  - inst_valid = queue not empty; inst_bits/inst_pc = queue head.
  - Pop on inst_valid&&inst_ready. Queue data is registered (no combinational path from io_data to inst_*).
  - Enqueue and dequeue in the same cycle: qcount unchanged.
  - Full queue: no enqueue can occur, by the credit rule.
- Redirect (redirect_valid=1):
  - Instruction queue flushed; a decode pop in the same cycle is ignored.
  - All issue-FIFO entries are marked stale, including one pushed in this cycle.
  - A response handshaking in the same cycle is discarded.
  - pc<=redirect_pc.
  - If an address is pending unaccepted: stale_pend<=1, and the held address is still issued.
  - On that handshake: the entry is pushed stale, pc is not incremented, and stale_pend<=0.
  - Back-to-back redirects: the latest target wins; stale marking repeats.
- Credit boundaries:
  - inflight+qcount==DEPTH: io_addr_valid=0 unless a request is pending.
  - A slot freed by a dequeue becomes visible next cycle (registered count).
- Invariants:
  - inflight<=DEPTH.
  - The issue FIFO never overflows.
  - Every inst_pc equals the address whose response produced inst_bits.
  - Delivered PCs follow the sequence RESET_PC, +4, ... until a redirect, then redirect_pc, +4, ...

Test Plan:
- Cache always ready, 1-cycle response, inst_ready=1 → addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 issued on consecutive cycles. Each delivered with matching inst_pc; no stall.
- inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 address handshakes, then io_addr_valid=0. On release, 4 instructions drain in order and issue resumes at 0xBFC00010.
- 3 requests in flight, redirect_pc=0x80 → the 3 responses are discarded (inst_valid stays 0). The next delivered inst_pc is 0x80, then 0x84.
- io_addr_ready=0 while 0xBFC00004 is pending, redirect to 0x40 → io_addr_bits stays 0xBFC00004 until ready. Its response is dropped; the next issued address is 0x40.
- Redirect in the same cycle as a response and a decode pop → the response is discarded, the queue is empty next cycle, and the first delivered inst_pc equals the target.
- reset driven low for 1 cycle mid-stream with 2 in flight → outputs low during reset. Fetch restarts at RESET_PC; leftover responses from before reset are not delivered (the bench suppresses them in this scenario).
